// File: rtl/id_exe_stage_reg.sv
// rtl/id_exe_stage_reg.sv - ID/EXE pipeline register with load-use hazard bubble insertion
module id_exe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int ALUC_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [DATA_W-1:0] id_rega,
    input  logic [DATA_W-1:0] id_regb,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_dreg,
    input  logic              id_wb_we,
    input  logic              id_mem_reg,
    input  logic              id_mem_we,
    input  logic [ALUC_W-1:0] id_aluc,
    input  logic              flush,
    input  logic              hold,
    output logic              stall,
    output logic              exe_valid,
    output logic [DATA_W-1:0] exe_rega,
    output logic [DATA_W-1:0] exe_regb,
    output logic [DATA_W-1:0] exe_imm,
    output logic [REG_W-1:0]  exe_dreg,
    output logic              exe_wb_we,
    output logic              exe_mem_reg,
    output logic              exe_mem_we,
    output logic [ALUC_W-1:0] exe_aluc,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic hazard;
    logic rs_match;
    logic rt_match;

    // A load in EXE whose result an ID source needs cannot be forwarded yet.
    always_comb begin
        rs_match = id_use_rs && (id_rs == exe_dreg);
        rt_match = id_use_rt && (id_rt == exe_dreg);
        hazard   = exe_valid && exe_wb_we && exe_mem_reg && (exe_dreg != '0) &&
                   id_valid && (rs_match || rt_match);
    end

    assign stall = hazard && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            exe_valid   <= 1'b0;
            exe_rega    <= '0;
            exe_regb    <= '0;
            exe_imm     <= '0;
            exe_dreg    <= '0;
            exe_wb_we   <= 1'b0;
            exe_mem_reg <= 1'b0;
            exe_mem_we  <= 1'b0;
            exe_aluc    <= '0;
            bubble_cnt  <= '0;
        end else if (hold) begin
            bubble_cnt <= bubble_cnt;
        end else if (flush || hazard) begin
            exe_valid   <= 1'b0;
            exe_rega    <= '0;
            exe_regb    <= '0;
            exe_imm     <= '0;
            exe_dreg    <= '0;
            exe_wb_we   <= 1'b0;
            exe_mem_reg <= 1'b0;
            exe_mem_we  <= 1'b0;
            exe_aluc    <= '0;
            // Only hazard bubbles are counted; squashes are not.
            if (!flush && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end else begin
            exe_valid   <= id_valid;
            exe_rega    <= id_rega;
            exe_regb    <= id_regb;
            exe_imm     <= id_imm;
            exe_dreg    <= id_dreg;
            exe_wb_we   <= id_wb_we && id_valid;
            exe_mem_reg <= id_mem_reg;
            exe_mem_we  <= id_mem_we && id_valid;
            exe_aluc    <= id_aluc;
        end
    end

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// tb/tb_id_exe_stage_reg.sv - self-checking bench for id_exe_stage_reg
module tb_id_exe_stage_reg;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic        v;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  d;
        logic        we;
        logic        mr;
        logic        mwe;
        logic [3:0]  aluc;
    } ex_t;

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_use_rs, id_use_rt, id_wb_we, id_mem_reg, id_mem_we;
    logic [4:0]  id_rs, id_rt, id_dreg;
    logic [31:0] id_rega, id_regb, id_imm;
    logic [3:0]  id_aluc;
    logic flush, hold;
    logic stall, exe_valid, exe_wb_we, exe_mem_reg, exe_mem_we;
    logic [31:0] exe_rega, exe_regb, exe_imm;
    logic [4:0]  exe_dreg;
    logic [3:0]  exe_aluc;
    logic [CNT_W-1:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    ex_t m;
    int  mcnt;
    ex_t act;

    id_exe_stage_reg #(.DATA_W(32), .REG_W(5), .ALUC_W(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rega(id_rega),
        .id_regb(id_regb), .id_imm(id_imm), .id_dreg(id_dreg), .id_wb_we(id_wb_we),
        .id_mem_reg(id_mem_reg), .id_mem_we(id_mem_we), .id_aluc(id_aluc),
        .flush(flush), .hold(hold), .stall(stall), .exe_valid(exe_valid),
        .exe_rega(exe_rega), .exe_regb(exe_regb), .exe_imm(exe_imm),
        .exe_dreg(exe_dreg), .exe_wb_we(exe_wb_we), .exe_mem_reg(exe_mem_reg),
        .exe_mem_we(exe_mem_we), .exe_aluc(exe_aluc), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    always_comb act = '{exe_valid, exe_rega, exe_regb, exe_imm, exe_dreg,
                        exe_wb_we, exe_mem_reg, exe_mem_we, exe_aluc};

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference rule: the load in EXE is needed by a real ID source.
    function automatic logic model_hazard();
        if (!(m.v && m.we && m.mr && m.d != 5'd0 && id_valid)) return 1'b0;
        return (id_use_rs && id_rs == m.d) || (id_use_rt && id_rt == m.d);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m    <= '0;
            mcnt <= 0;
        end else if (hold) begin
            m <= m;
        end else if (flush) begin
            m <= '0;
        end else if (model_hazard()) begin
            m    <= '0;
            mcnt <= (mcnt < CNT_MAX) ? mcnt + 1 : mcnt;
        end else begin
            m <= '{id_valid, id_rega, id_regb, id_imm, id_dreg,
                   id_wb_we & id_valid, id_mem_reg, id_mem_we & id_valid, id_aluc};
        end
    end

    always @(negedge clk) begin
        check("model_exe", 128'(act), 128'(m));
        check("model_cnt", 128'(bubble_cnt), 128'(mcnt));
        check("model_stall", 128'(stall), 128'(model_hazard() && !rst));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic [4:0] d,
                          input logic we, input logic mr, input logic mwe,
                          input logic [31:0] a);
        id_valid = v;  id_rs = rs;  id_rt = rt;  id_use_rs = urs;  id_use_rt = urt;
        id_dreg = d;   id_wb_we = we;  id_mem_reg = mr;  id_mem_we = mwe;
        id_rega = a;   id_regb = a ^ 32'h0F0F_0F0F;  id_imm = a + 32'd4;
        id_aluc = a[3:0];
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; hold = 1'b0;
        // Test 1: reset with random ID contents
        for (int i = 0; i < 2; i++) begin
            set_id(1'b1, 5'($urandom), 5'($urandom), 1'b1, 1'b1, 5'($urandom),
                   1'b1, 1'b1, 1'b0, $urandom);
            tick();
        end
        check("rst_exe", 128'(act), 128'd0);
        check("rst_cnt", 128'(bubble_cnt), 128'd0);
        #1 check("rst_stall", 128'(stall), 128'd0);
        rst = 1'b0;

        // Test 2: lw r5 then add r6,r5,r7
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 32'h100);
        tick();
        set_id(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 32'h1234);
        #1 check("lu_stall", 128'(stall), 128'd1);
        tick();
        check("lu_bubble_v", 128'(exe_valid), 128'd0);
        check("lu_bubble_we", 128'(exe_wb_we), 128'd0);
        check("lu_cnt", 128'(bubble_cnt), 128'd1);
        #1 check("lu_stall_clr", 128'(stall), 128'd0);
        tick();
        check("lu_add_d", 128'(exe_dreg), 128'd6);
        check("lu_add_a", 128'(exe_rega), 128'h1234);

        // Test 3: lw r0 never hazards
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h200);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 32'h300);
        #1 check("r0_stall", 128'(stall), 128'd0);
        tick();
        check("r0_load_v", 128'(exe_valid), 128'd1);
        check("r0_cnt", 128'(bubble_cnt), 128'd1);

        // Test 4: non-load producer, forwarding handles it
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 32'h400);
        tick();
        set_id(1'b1, 5'd3, 5'd5, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 32'h500);
        #1 check("alu_stall", 128'(stall), 128'd0);
        tick();
        check("alu_load_d", 128'(exe_dreg), 128'd9);

        // Invalid ID slot: write enables forced low
        set_id(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b1, 32'h600);
        tick();
        check("inv_we", 128'({exe_valid, exe_wb_we, exe_mem_we}), 128'd0);

        // Test 5: flush squashes
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_v", 128'(exe_valid), 128'd0);
        check("fl_a", 128'(exe_rega), 128'd0);
        check("fl_cnt", 128'(bubble_cnt), 128'd1);

        // Test 6: hold over a pending hazard
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0, 32'h700);
        tick();
        set_id(1'b1, 5'd4, 5'd12, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 32'h800);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("hold_stall", 128'(stall), 128'd1);
            tick();
            check("hold_frozen_d", 128'(exe_dreg), 128'd12);
            check("hold_cnt", 128'(bubble_cnt), 128'd1);
        end
        hold = 1'b0;
        tick();
        check("rel_v", 128'(exe_valid), 128'd0);
        check("rel_cnt", 128'(bubble_cnt), 128'd2);
        tick();
        check("rel_load_d", 128'(exe_dreg), 128'd13);

        // Saturation: a self-dependent load alternates load/bubble
        set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 32'h900);
        for (int i = 0; i < 2 * CNT_MAX + 10; i++) tick();
        check("sat_cnt", 128'(bubble_cnt), 128'(CNT_MAX));
        tick();
        tick();
        check("sat_hold", 128'(bubble_cnt), 128'(CNT_MAX));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
